fitbit_step_tracker: RTL and testbench

Consumer of the divided one-second clock. It samples `slowclk` and a raw step pulse in the `otherclk` domain. From those it keeps a saturating running step total, a per-second step rate, and an activity-streak tracker for the display and alert logic. Each `slowclk` rising edge closes a one-second measurement window.

---
 rtl/fitbit_step_tracker.sv | 74 +++++++
 tb/tb_fitbit_step_tracker.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fitbit_step_tracker.sv
// fitbit_step_tracker: step total, per-second step rate and activity streaks driven by a synchronized slow clock
module fitbit_step_tracker #(
  parameter int TOTAL_MAX     = 9999,
  parameter int RATE_W        = 8,
  parameter int ACTIVE_THRESH = 2
) (
  input  logic              otherclk,
  input  logic              reset,
  input  logic              slowclk,
  input  logic              step_in,
  output logic [13:0]       total_steps,
  output logic              total_sat,
  output logic [RATE_W-1:0] steps_last_sec,
  output logic              sec_tick,
  output logic              rate_valid,
  output logic [7:0]        active_streak,
  output logic [7:0]        best_streak
);
  typedef enum logic {WAIT_SYNC, RUN} state_t;
  state_t state;
  logic [2:0] slow_sy, step_sy;
  logic slow_rise, step_rise, active;
  logic [RATE_W-1:0] win, win_inc, close_cnt;
  logic [13:0] total_nxt;
  logic [7:0] streak_nxt;
  always_comb begin
    win_inc    = &win ? win : win + 1'b1;
    close_cnt  = step_rise ? win_inc : win;
    total_nxt  = (step_rise && total_steps != 14'(TOTAL_MAX)) ? total_steps + 14'd1 : total_steps;
    active     = int'(close_cnt) >= ACTIVE_THRESH;
    streak_nxt = !active ? 8'd0 : (&active_streak ? active_streak : active_streak + 8'd1);
  end
  // edge pulses are registered so outputs update three edges after first sample
  always_ff @(posedge otherclk) begin
    if (reset) begin
      state          <= WAIT_SYNC;
      slow_sy        <= '0;
      step_sy        <= '0;
      slow_rise      <= 1'b0;
      step_rise      <= 1'b0;
      win            <= '0;
      total_steps    <= '0;
      total_sat      <= 1'b0;
      steps_last_sec <= '0;
      sec_tick       <= 1'b0;
      rate_valid     <= 1'b0;
      active_streak  <= '0;
      best_streak    <= '0;
    end else begin
      slow_sy     <= {slow_sy[1:0], slowclk};
      step_sy     <= {step_sy[1:0], step_in};
      slow_rise   <= slow_sy[1] & ~slow_sy[2];
      step_rise   <= step_sy[1] & ~step_sy[2];
      total_steps <= total_nxt;
      total_sat   <= total_sat | (total_nxt == 14'(TOTAL_MAX));
      sec_tick    <= 1'b0;
      if (state == WAIT_SYNC) begin
        if (slow_rise) begin
          state <= RUN;
          win   <= '0;
        end
      end else if (slow_rise) begin
        steps_last_sec <= close_cnt;
        win            <= '0;
        sec_tick       <= 1'b1;
        rate_valid     <= 1'b1;
        active_streak  <= streak_nxt;
        best_streak    <= streak_nxt > best_streak ? streak_nxt : best_streak;
      end else begin
        win <= close_cnt;
      end
    end
  end
endmodule

// File: tb/tb_fitbit_step_tracker.sv
// tb_fitbit_step_tracker: directed checks of totals, windows, streaks and reset
module tb_fitbit_step_tracker;
  logic clk = 0, rst = 1, slowclk = 0, step_in = 0;
  logic [13:0] total_steps, total_b;
  logic total_sat, sat_b, sec_tick, tick_b, rate_valid, valid_b;
  logic [7:0] steps_last_sec, rate_b, active_streak, act_b, best_streak, best_b;
  int n_vec = 0, n_err = 0, ticks = 0, tk_rate = 0, tk_valid = 0, tk_act = 0;

  fitbit_step_tracker dut (
    .otherclk(clk), .reset(rst), .slowclk(slowclk), .step_in(step_in),
    .total_steps(total_steps), .total_sat(total_sat), .steps_last_sec(steps_last_sec),
    .sec_tick(sec_tick), .rate_valid(rate_valid), .active_streak(active_streak),
    .best_streak(best_streak)
  );
  fitbit_step_tracker #(.TOTAL_MAX(10)) dut_b (
    .otherclk(clk), .reset(rst), .slowclk(slowclk), .step_in(step_in),
    .total_steps(total_b), .total_sat(sat_b), .steps_last_sec(rate_b),
    .sec_tick(tick_b), .rate_valid(valid_b), .active_streak(act_b),
    .best_streak(best_b)
  );

  always #5 clk = ~clk;

  // snapshot the outputs seen during the sec_tick cycle itself
  always @(negedge clk) if (sec_tick) begin
    ticks    = ticks + 1;
    tk_rate  = int'(steps_last_sec);
    tk_valid = int'(rate_valid);
    tk_act   = int'(active_streak);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    step_in = 1;
    tick(4);
    step_in = 0;
    tick(4);
  endtask

  task automatic close_win(input string tag, input int exp_ticks);
    int t0;
    t0 = ticks;
    slowclk = 1;
    tick(8);
    slowclk = 0;
    tick(8);
    chk(tag, ticks - t0, exp_ticks);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_total"}, int'(total_steps), 0);
    chk({tag, "_sat"}, int'(total_sat), 0);
    chk({tag, "_rate"}, int'(steps_last_sec), 0);
    chk({tag, "_tick"}, int'(sec_tick), 0);
    chk({tag, "_valid"}, int'(rate_valid), 0);
    chk({tag, "_act"}, int'(active_streak), 0);
    chk({tag, "_best"}, int'(best_streak), 0);
  endtask

  initial begin
    tick(3);
    rst = 0;
    chk_zero("rst");
    chk("rst_b_total", int'(total_b), 0);
    for (int i = 1; i <= 5; i++) pulse();
    chk("pre_total", int'(total_steps), 5);
    chk("pre_valid", int'(rate_valid), 0);
    chk("pre_ticks", ticks, 0);
    for (int i = 6; i <= 12; i++) begin
      pulse();
      chk($sformatf("satb_total%0d", i), int'(total_b), i < 10 ? i : 10);
      chk($sformatf("satb_flag%0d", i), int'(sat_b), i >= 10 ? 1 : 0);
    end
    chk("main_total12", int'(total_steps), 12);
    chk("main_sat", int'(total_sat), 0);
    close_win("first_edge_ticks", 0);
    for (int i = 0; i < 3; i++) pulse();
    close_win("w1_ticks", 1);
    chk("w1_rate", int'(steps_last_sec), 3);
    chk("w1_tk_rate", tk_rate, 3);
    chk("w1_tk_valid", tk_valid, 1);
    chk("w1_tk_act", tk_act, 1);
    chk("w1_best", int'(best_streak), 1);
    close_win("w2_ticks", 1);
    chk("w2_rate", int'(steps_last_sec), 0);
    chk("w2_act", int'(active_streak), 0);
    chk("w2_best", int'(best_streak), 1);
    pulse();
    step_in = 1;
    slowclk = 1;
    tick(8);
    step_in = 0;
    slowclk = 0;
    tick(8);
    chk("sim_rate", int'(steps_last_sec), 2);
    chk("sim_tk_act", tk_act, 1);
    close_win("sim_next_ticks", 1);
    chk("sim_next_rate", int'(steps_last_sec), 0);
    for (int s = 0; s < 4; s++) begin
      pulse();
      pulse();
      close_win("streak_ticks", 1);
    end
    chk("streak4_act", int'(active_streak), 4);
    chk("streak4_best", int'(best_streak), 4);
    close_win("idle_ticks", 1);
    chk("idle_act", int'(active_streak), 0);
    for (int s = 0; s < 2; s++) begin
      pulse();
      pulse();
      close_win("streak_ticks", 1);
    end
    chk("final_act", int'(active_streak), 2);
    chk("final_best", int'(best_streak), 4);
    rst = 1;
    tick(3);
    rst = 0;
    close_win("rs_first_ticks", 0);
    for (int i = 0; i < 7; i++) pulse();
    chk("rs_total7", int'(total_steps), 7);
    rst = 1;
    tick(1);
    rst = 0;
    chk_zero("midrst");
    close_win("midrst_edge_ticks", 0);
    chk("midrst_valid", int'(rate_valid), 0);
    close_win("midrst_next_ticks", 1);
    chk("midrst_next_valid", int'(rate_valid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
